// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default timeout and counter sizing.
package apb_pkg;

    // Initiator FSM states; the encoding is shared with future APB blocks.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Default number of ACCESS cycles allowed before a transfer is aborted.
    localparam int unsigned APB_TIMEOUT_DEF = 16;

    // Width of a counter that must reach timeout-1; never narrower than one bit.
    function automatic int unsigned apb_cnt_width(input int unsigned timeout);
        int unsigned w;
        w = 1;
        while ((1 << w) < timeout) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Clearable wait-state counter with a terminal-count flag at TIMEOUT-1.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int unsigned          CNT_W  = apb_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]     TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready command in, APB transfer out,
// valid/ready response back carrying read data or a timeout error.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    apb_state_e        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic timer_clr;
    logic timer_inc;
    logic timer_tc;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i (pclk),
        .rst_i (preset),
        .clr_i (timer_clr),
        .inc_i (timer_inc),
        .tc_o  (timer_tc)
    );

    // Next-state, command capture and response capture; control outputs are
    // decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Counter starts from zero on the first ACCESS cycle.
                timer_clr = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (timer_tc) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and handshake/control flops.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // APB address/data registers; held after the transfer ends.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    // Response registers; stable throughout RESP until the consumer takes them.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: a driver issues commands and pushes
// the expected response, an APB slave model serves the bus, and a monitor pops
// and compares every response the bridge presents.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          pclk;
    logic          preset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;

    apb_master_bridge #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
        int            acc;
    } exp_t;

    typedef struct {
        int            w;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } sl_t;

    exp_t          exp_q[$];
    sl_t           sl_q[$];
    logic [DW-1:0] ref_mem[8];
    logic [DW-1:0] sl_mem[8];
    int            tests = 0;
    int            fails = 0;
    int            pcyc  = 0;
    int            stall_cfg = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) pcyc <= pcyc + 1;

    // rsp_ready: stall each response for stall_cfg cycles (random when negative)
    int stall_left = 0;
    bit rv_prev    = 1'b0;
    always @(posedge pclk) begin
        #1;
        if (preset) begin
            rv_prev   = 1'b0;
            rsp_ready = 1'b1;
        end else if (rsp_valid) begin
            if (!rv_prev) stall_left = (stall_cfg >= 0) ? stall_cfg : int'($urandom_range(0, 3));
            rsp_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            rv_prev = 1'b1;
        end else begin
            rv_prev   = 1'b0;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // APB slave model: memory of 8 words, inserts the wait count queued by the driver
    sl_t cur;
    int  acc_cnt = 0;
    bit  cur_vld = 1'b0;
    always @(negedge pclk) begin
        if (preset) begin
            pready  = 1'b0;
            prdata  = DW'($urandom);
            cur_vld = 1'b0;
        end else if (psel && !penable) begin
            chk("setup_pending", sl_q.size(), 1);
            if (sl_q.size() > 0) begin
                cur     = sl_q.pop_front();
                cur_vld = 1'b1;
                acc_cnt = 0;
                chk("setup_bus", {pwrite, paddr, pwdata}, {cur.wr, cur.addr, cur.wdata});
            end
            pready = 1'($urandom_range(0, 1));
            prdata = DW'($urandom);
        end else if (psel && penable) begin
            if (cur_vld) begin
                chk("access_bus_stable", {pwrite, paddr, pwdata}, {cur.wr, cur.addr, cur.wdata});
                if (acc_cnt == cur.w) begin
                    pready = 1'b1;
                    if (pwrite) begin
                        sl_mem[paddr[4:2]] = pwdata;
                        prdata = DW'($urandom);
                    end else begin
                        prdata = sl_mem[paddr[4:2]];
                    end
                end else begin
                    pready = 1'b0;
                    prdata = DW'($urandom);
                end
                acc_cnt++;
            end else begin
                pready = 1'b0;
                prdata = DW'($urandom);
            end
        end else begin
            pready = 1'($urandom_range(0, 1));
            prdata = DW'($urandom);
        end
    end

    // Response monitor / scoreboard
    bit            in_resp  = 1'b0;
    bit            exp_idle = 1'b0;
    logic          hold_err;
    logic [DW-1:0] hold_rd;
    always @(negedge pclk) begin
        exp_t e;
        if (preset) begin
            in_resp  = 1'b0;
            exp_idle = 1'b0;
        end else begin
            if (penable) chk("penable_needs_psel", psel, 1);
            if (exp_idle) begin
                chk("idle_after_resp", {rsp_valid, cmd_ready}, 2'b01);
                exp_idle = 1'b0;
            end
            if (rsp_valid) begin
                chk("resp_quiet_bus", {psel, penable, cmd_ready}, 3'b000);
                if (!in_resp) begin
                    chk("resp_pending", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_latency", pcyc - e.acc, e.lat);
                    end
                    in_resp  = 1'b1;
                    hold_err = rsp_err;
                    hold_rd  = rsp_rdata;
                end else begin
                    chk("rsp_hold", {rsp_err, rsp_rdata}, {hold_err, hold_rd});
                end
                if (rsp_ready) begin
                    in_resp  = 1'b0;
                    exp_idle = 1'b1;
                end
            end
        end
    end

    // Issue one command (call at a negedge); w = slave wait states before pready.
    task automatic issue(input bit wr, input int idx, input logic [DW-1:0] wd,
                         input int w, output int acc);
        exp_t e;
        sl_t  s;
        int   guard;
        bit   succ;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = AW'(idx * 4);
        cmd_wdata = wd;
        guard = 0;
        while (!cmd_ready && guard < 300) begin
            @(negedge pclk);
            guard++;
        end
        chk("cmd_accept", cmd_ready, 1);
        acc = pcyc;
        if (cmd_ready) begin
            succ = (w < TO);
            if (wr && succ) ref_mem[idx] = wd;
            e.err   = !succ;
            e.rdata = (!wr && succ) ? ref_mem[idx] : '0;
            e.lat   = (succ ? w : TO - 1) + 3;
            e.acc   = pcyc;
            exp_q.push_back(e);
            s.w     = w;
            s.wr    = wr;
            s.addr  = AW'(idx * 4);
            s.wdata = wd;
            sl_q.push_back(s);
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || rsp_valid) && guard < 400) begin
            @(negedge pclk);
            guard++;
        end
        chk("drain", exp_q.size(), 0);
        @(negedge pclk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3, guard, r, w;
        logic [DW-1:0] v;
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            v = (i == 2) ? 32'h1234_5678 : DW'($urandom);
            ref_mem[i] = v;
            sl_mem[i]  = v;
        end
        repeat (3) @(negedge pclk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_psel_penable_pwrite", {psel, penable, pwrite}, 3'b000);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        preset = 1'b0;

        // zero-wait write, then read with 3 wait states
        stall_cfg = 0;
        issue(1'b1, 1, 32'hA5A5_0001, 0, a0);
        drain();
        issue(1'b0, 2, DW'($urandom), 3, a0);
        drain();

        // timeout boundaries: abort, success on the last ACCESS cycle, abort, normal
        issue(1'b0, 3, DW'($urandom), 20, a0);
        issue(1'b1, 3, 32'hCAFE_0003, TO - 1, a0);
        issue(1'b0, 3, DW'($urandom), TO, a0);
        issue(1'b0, 3, DW'($urandom), 0, a0);
        drain();

        // response backpressure for 5 cycles with the next command waiting
        stall_cfg = 5;
        issue(1'b1, 5, 32'h0BAD_F00D, 1, a0);
        issue(1'b0, 5, DW'($urandom), 0, a0);
        drain();
        stall_cfg = 0;

        // back-to-back write then read-back: one acceptance every 4 cycles
        issue(1'b1, 6, 32'h0000_00F0, 0, a1);
        issue(1'b0, 6, DW'($urandom), 0, a2);
        issue(1'b0, 7, DW'($urandom), 0, a3);
        chk("b2b_gap1", a2 - a1, 4);
        chk("b2b_gap2", a3 - a2, 4);
        drain();

        // reset asserted in the middle of ACCESS
        issue(1'b0, 4, DW'($urandom), 10, a0);
        guard = 0;
        while (!(psel && penable) && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        chk("reach_access", {psel, penable}, 2'b11);
        #2;
        preset = 1'b1;
        #1;
        chk("midrst_psel_penable", {psel, penable}, 2'b00);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        sl_q.delete();
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        issue(1'b0, 4, DW'($urandom), 2, a0);
        issue(1'b1, 4, 32'h5555_AAAA, 0, a0);
        issue(1'b0, 4, DW'($urandom), 1, a0);
        drain();

        // randomized traffic with random gaps, wait states and backpressure
        stall_cfg = -1;
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            r = int'($urandom_range(0, 9));
            if (r < 6)      w = int'($urandom_range(0, 3));
            else if (r < 8) w = int'($urandom_range(4, 12));
            else            w = int'($urandom_range(13, 19));
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), DW'($urandom), w, a0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
